// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - shares one UART TX between RF read bytes and two-byte ALU results.
// Optional build macro UART_TX_SCHED_RR_EN selects round-robin arbitration (default: ALU over RF).
module uart_tx_sched #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VALID,
  output logic                    RF_RD_READY,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic                    ALU_READY,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_DATA_VALID,
  output logic                    SCHED_BUSY,
  output logic                    GRANT_ALU
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic [DATA_WIDTH-1:0] r_hi_byte;
  logic                  r_idx;
  logic                  r_grant_alu;
`ifdef UART_TX_SCHED_RR_EN
  logic                  r_last_alu;
`endif

  logic w_grant;
  logic w_pick_alu;

  // RST gates the strobes so every output drops the instant reset asserts.
  assign w_grant = (r_state == S_IDLE) && !TX_BUSY && !RST && (RF_RD_VALID || ALU_OUT_VALID);

`ifdef UART_TX_SCHED_RR_EN
  assign w_pick_alu = (RF_RD_VALID && ALU_OUT_VALID) ? !r_last_alu : ALU_OUT_VALID;
`else
  assign w_pick_alu = ALU_OUT_VALID;
`endif

  assign RF_RD_READY   = w_grant && !w_pick_alu;
  assign ALU_READY     = w_grant && w_pick_alu;
  assign TX_DATA_VALID = (r_state == S_LOAD);
  assign SCHED_BUSY    = (r_state != S_IDLE);
  assign TX_P_DATA     = r_p_data;
  assign GRANT_ALU     = r_grant_alu;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_p_data    <= '0;
      r_hi_byte   <= '0;
      r_idx       <= 1'b0;
      r_grant_alu <= 1'b0;
`ifdef UART_TX_SCHED_RR_EN
      r_last_alu  <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_grant_alu <= w_pick_alu;
            r_idx       <= 1'b0;
            r_hi_byte   <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
            r_p_data    <= w_pick_alu ? ALU_OUT[DATA_WIDTH-1:0] : RF_RD_DATA;
`ifdef UART_TX_SCHED_RR_EN
            r_last_alu  <= w_pick_alu;
`endif
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: r_state <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (TX_BUSY) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!TX_BUSY) begin
            // ALU words go out low byte first, high byte straight after.
            if (r_grant_alu && !r_idx) begin
              r_idx    <= 1'b1;
              r_p_data <= r_hi_byte;
              r_state  <= S_LOAD;
            end else begin
              r_state  <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched with a registered-Busy TX model.
module tb_uart_tx_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_VALID;
  logic        RF_RD_READY;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic        ALU_READY;
  logic        TX_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_DATA_VALID;
  logic        SCHED_BUSY;
  logic        GRANT_ALU;

  int tests_run = 0;
  int tests_failed = 0;

  uart_tx_sched #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VALID(RF_RD_VALID), .RF_RD_READY(RF_RD_READY),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID), .ALU_READY(ALU_READY),
    .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
    .SCHED_BUSY(SCHED_BUSY), .GRANT_ALU(GRANT_ALU)
  );

  always #5 CLK = ~CLK;

  // TX model: Busy rises 2 cycles after the load strobe and stays high for 10 cycles.
  logic m_pend, m_busy, force_busy;
  int   m_cnt;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pend <= 1'b0;
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_pend <= TX_DATA_VALID;
      if (m_pend) begin
        m_busy <= 1'b1;
        m_cnt  <= 10;
      end else if (m_busy) begin
        if (m_cnt == 1) m_busy <= 1'b0;
        m_cnt <= m_cnt - 1;
      end
    end
  end
  assign TX_BUSY = m_busy | force_busy;

  int          v_cyc[$];
  logic [7:0]  v_dat[$];
  int          f_cyc[$];
  int          g_cyc[$];
  bit          g_who[$];
  int          idle_cyc;
  int          viol = 0;
  bit          drop_rf, drop_alu;

  // Runs n cycles from just after a rising edge, logging events by cycle index.
  task automatic run(input int n);
    bit prev_busy, seen_busy, kill_rf, kill_alu;
    v_cyc.delete(); v_dat.delete(); f_cyc.delete(); g_cyc.delete(); g_who.delete();
    idle_cyc = -1;
    prev_busy = TX_BUSY;
    seen_busy = SCHED_BUSY;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      kill_rf = 1'b0;
      kill_alu = 1'b0;
      if (TX_DATA_VALID) begin v_cyc.push_back(i); v_dat.push_back(TX_P_DATA); end
      if (prev_busy && !TX_BUSY) f_cyc.push_back(i);
      prev_busy = TX_BUSY;
      if (SCHED_BUSY) seen_busy = 1'b1;
      else if (seen_busy && idle_cyc < 0) idle_cyc = i;
      if ((RF_RD_READY || ALU_READY) && (SCHED_BUSY || (RF_RD_READY && ALU_READY))) viol++;
      if (RF_RD_READY) begin g_cyc.push_back(i); g_who.push_back(1'b0); kill_rf = drop_rf; end
      if (ALU_READY) begin g_cyc.push_back(i); g_who.push_back(1'b1); kill_alu = drop_alu; end
      @(posedge CLK);
      #1;
      if (kill_rf) RF_RD_VALID = 1'b0;
      if (kill_alu) ALU_OUT_VALID = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #1;
    tests_run++;
    if ({TX_P_DATA, TX_DATA_VALID, RF_RD_READY, ALU_READY, SCHED_BUSY, GRANT_ALU} !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want 0", {TX_P_DATA, TX_DATA_VALID, RF_RD_READY, ALU_READY, SCHED_BUSY, GRANT_ALU});
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_rf_single();
    RF_RD_DATA = 8'hA5; RF_RD_VALID = 1'b1; drop_rf = 1'b1;
    run(20);
    tests_run++;
    if (g_cyc.size() != 1 || g_cyc[0] != 0 || g_who[0] != 1'b0) begin
      tests_failed++; $display("FAIL rf_ready_pulse: got %0d grants, first at %0d, want 1 RF grant at 0", g_cyc.size(), g_cyc.size() ? g_cyc[0] : -1);
    end
    tests_run++;
    if (v_cyc.size() != 1 || v_cyc[0] != 1 || v_dat[0] !== 8'hA5) begin
      tests_failed++; $display("FAIL rf_tx_load: got %0d loads, first data %h, want 1 load at cycle 1 data a5", v_cyc.size(), v_dat.size() ? v_dat[0] : 8'h0);
    end
    tests_run++;
    if (f_cyc.size() != 1 || idle_cyc != f_cyc[0] + 1 || idle_cyc != 14) begin
      tests_failed++; $display("FAIL rf_idle_return: got idle %0d, want 14 (one after busy fall)", idle_cyc);
    end
    tests_run++;
    if (GRANT_ALU !== 1'b0 || TX_P_DATA !== 8'hA5) begin
      tests_failed++; $display("FAIL rf_hold: got grant %b data %h, want 0 a5", GRANT_ALU, TX_P_DATA);
    end
    drop_rf = 1'b0;
  endtask

  task automatic test_alu_word();
    ALU_OUT = 16'h1234; ALU_OUT_VALID = 1'b1; drop_alu = 1'b1;
    run(32);
    tests_run++;
    if (g_cyc.size() != 1 || g_who[0] != 1'b1 || g_cyc[0] != 0) begin
      tests_failed++; $display("FAIL alu_ready_pulse: got %0d grants, want 1 ALU grant at 0", g_cyc.size());
    end
    tests_run++;
    if (v_cyc.size() != 2 || v_dat[0] !== 8'h34 || v_dat[1] !== 8'h12) begin
      tests_failed++; $display("FAIL alu_bytes: got %0d loads %h %h, want 2 loads 34 12", v_cyc.size(), v_dat.size() > 0 ? v_dat[0] : 8'h0, v_dat.size() > 1 ? v_dat[1] : 8'h0);
    end
    tests_run++;
    if (v_cyc.size() != 2 || f_cyc.size() < 1 || v_cyc[1] != f_cyc[0] + 1 || v_cyc[1] != 14) begin
      tests_failed++; $display("FAIL alu_second_timing: got second load at %0d, want 14", v_cyc.size() > 1 ? v_cyc[1] : -1);
    end
    tests_run++;
    if (idle_cyc != 27 || GRANT_ALU !== 1'b1 || TX_P_DATA !== 8'h12) begin
      tests_failed++; $display("FAIL alu_idle: got idle %0d grant %b data %h, want 27 1 12", idle_cyc, GRANT_ALU, TX_P_DATA);
    end
    drop_alu = 1'b0;
  endtask

  task automatic test_arbitration();
    RF_RD_DATA = 8'h11; ALU_OUT = 16'h2233;
    RF_RD_VALID = 1'b1; ALU_OUT_VALID = 1'b1;
    run(60);
`ifdef UART_TX_SCHED_RR_EN
    tests_run++;
    if (g_who.size() != 4 || g_who[0] != 0 || g_who[1] != 1 || g_who[2] != 0 || g_who[3] != 1) begin
      tests_failed++; $display("FAIL rr_order: got %0d grants, want RF ALU RF ALU", g_who.size());
    end
    tests_run++;
    if (g_cyc.size() != 4 || g_cyc[1] != 14 || g_cyc[2] != 41 || g_cyc[3] != 55) begin
      tests_failed++; $display("FAIL rr_timing: got grant cycles wrong (count %0d), want 0 14 41 55", g_cyc.size());
    end
    RF_RD_VALID = 1'b0; ALU_OUT_VALID = 1'b0;
    run(40);
`else
    tests_run++;
    if (g_who.size() != 3 || g_who[0] != 1 || g_who[1] != 1 || g_who[2] != 1) begin
      tests_failed++; $display("FAIL fixed_alu_first: got %0d grants, want 3 ALU grants", g_who.size());
    end
    ALU_OUT_VALID = 1'b0; drop_rf = 1'b1;
    run(50);
    tests_run++;
    if (g_who.size() != 1 || g_who[0] != 0 || g_cyc[0] != 21) begin
      tests_failed++; $display("FAIL fixed_rf_after: got %0d grants first at %0d, want 1 RF grant at 21", g_who.size(), g_cyc.size() ? g_cyc[0] : -1);
    end
    drop_rf = 1'b0;
`endif
  endtask

  task automatic test_busy_block();
    force_busy = 1'b1; RF_RD_DATA = 8'h5A; RF_RD_VALID = 1'b1; drop_rf = 1'b1;
    run(5);
    tests_run++;
    if (g_cyc.size() != 0 || v_cyc.size() != 0) begin
      tests_failed++; $display("FAIL busy_block: got %0d grants %0d loads, want 0 0", g_cyc.size(), v_cyc.size());
    end
    force_busy = 1'b0;
    run(20);
    tests_run++;
    if (g_cyc.size() != 1 || g_cyc[0] != 0 || v_cyc.size() != 1 || v_dat[0] !== 8'h5A) begin
      tests_failed++; $display("FAIL busy_release: got %0d grants %0d loads, want RF grant at 0 and load 5a", g_cyc.size(), v_cyc.size());
    end
    drop_rf = 1'b0;
  endtask

  task automatic test_reset_mid();
    ALU_OUT = 16'hBEEF; ALU_OUT_VALID = 1'b1; drop_alu = 1'b1;
    run(8);
    tests_run++;
    if (SCHED_BUSY !== 1'b1 || TX_P_DATA !== 8'hEF) begin
      tests_failed++; $display("FAIL mid_pre: got busy %b data %h, want 1 ef", SCHED_BUSY, TX_P_DATA);
    end
    RST = 1'b1;
    #1;
    tests_run++;
    if ({TX_P_DATA, TX_DATA_VALID, RF_RD_READY, ALU_READY, SCHED_BUSY, GRANT_ALU} !== 13'h0) begin
      tests_failed++; $display("FAIL mid_reset_outputs: got %h want 0", {TX_P_DATA, TX_DATA_VALID, RF_RD_READY, ALU_READY, SCHED_BUSY, GRANT_ALU});
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    run(30);
    tests_run++;
    if (v_cyc.size() != 0) begin
      tests_failed++; $display("FAIL mid_no_second: got %0d loads, want 0", v_cyc.size());
    end
    drop_alu = 1'b0;
    RF_RD_DATA = 8'h3C; RF_RD_VALID = 1'b1; drop_rf = 1'b1;
    run(20);
    tests_run++;
    if (g_cyc.size() != 1 || g_cyc[0] != 0 || v_cyc.size() != 1 || v_cyc[0] != 1 || v_dat[0] !== 8'h3C) begin
      tests_failed++; $display("FAIL mid_after_release: got %0d grants %0d loads, want RF grant at 0 load 3c at 1", g_cyc.size(), v_cyc.size());
    end
    drop_rf = 1'b0;
  endtask

  initial begin
    RF_RD_DATA = 8'h00; RF_RD_VALID = 1'b0; ALU_OUT = 16'h0000; ALU_OUT_VALID = 1'b0;
    force_busy = 1'b0; drop_rf = 1'b0; drop_alu = 1'b0;
    test_reset();
    test_rf_single();
    test_alu_word();
    test_arbitration();
    test_busy_block();
    test_reset_mid();
    tests_run++;
    if (viol != 0) begin
      tests_failed++; $display("FAIL ready_rules: got %0d bad READY cycles, want 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
